// File: rtl/lumi_regs_mc.sv
// Multi-channel LUMI control register block: sideband register file, per-channel
// link qualification FSMs with settle delay, auto-config on link-up, and a sticky event irq.
module lumi_regs_mc #(
  parameter int          NCH       = 2,
  parameter int          RW        = 32,
  parameter int          REGAW     = 8,
  parameter int          LINKDLY   = 16,
  parameter int          CRDTDEPTH = 19,
  parameter logic [15:0] INTRVLRST = 16'h00FF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                devicemode,
  input  logic                deviceready,
  input  logic                reg_req_valid,
  input  logic                reg_req_write,
  input  logic [REGAW-1:0]    reg_req_addr,
  input  logic [RW-1:0]       reg_req_wrdata,
  output logic                reg_req_ready,
  output logic                reg_resp_valid,
  output logic [RW-1:0]       reg_resp_rddata,
  output logic                reg_resp_error,
  input  logic                reg_resp_ready,
  input  logic [NCH-1:0]      phy_linkactive,
  input  logic [8*NCH-1:0]    phy_iow,
  output logic [NCH-1:0]      linkactive,
  output logic                irq,
  output logic [1:0]          csr_arbmode,
  output logic [NCH-1:0]      csr_txen,
  output logic [NCH-1:0]      csr_txcrdt_en,
  output logic [NCH-1:0]      csr_rxen,
  output logic [8*NCH-1:0]    csr_txiowidth,
  output logic [8*NCH-1:0]    csr_rxiowidth,
  output logic [16*NCH-1:0]   csr_txcrdt_intrvl,
  output logic [16*NCH-1:0]   csr_rxcrdt_req_init,
  output logic [16*NCH-1:0]   csr_rxcrdt_resp_init,
  input  logic [32*NCH-1:0]   csr_txcrdt_status
);

  typedef enum logic [1:0] {DOWN, SETTLE, UP} state_t;

  state_t        state    [NCH];
  logic [15:0]   cnt      [NCH];
  logic [RW-1:0] txmode   [NCH];
  logic [RW-1:0] rxmode   [NCH];
  logic [RW-1:0] crdtinit [NCH];
  logic [15:0]   intrvl   [NCH];
  logic [1:0]    arbmode;
  logic [RW-1:0] evt, eventen, set_ev, rd;
  logic [NCH-1:0] qual, load, down_ev, wr_tx, wr_rx, wr_ci, wr_iv;
  logic          acc, wr, err, wr_ctrl, wr_evt, wr_even;
  int            word, chn, off;
  logic [1:0]    addr_unused;

  function automatic logic [15:0] crdt_sat(input logic [7:0] iow);
    logic [31:0] s;
    s = 32'(CRDTDEPTH) << iow;
    crdt_sat = (s > 32'h0000_FFFF) ? 16'hFFFF : s[15:0];
  endfunction

  assign addr_unused   = reg_req_addr[1:0];
  assign reg_req_ready = ~reg_resp_valid;

  // Address decode and read mux
  always_comb begin
    acc = reg_req_valid & ~reg_resp_valid;
    wr = acc & reg_req_write;
    word = int'(reg_req_addr[REGAW-1:2]);
    chn = 0;
    off = 0;
    rd = '0;
    err = 1'b0;
    wr_ctrl = 1'b0;
    wr_evt = 1'b0;
    wr_even = 1'b0;
    wr_tx = '0;
    wr_rx = '0;
    wr_ci = '0;
    wr_iv = '0;
    if (word < 4) begin
      case (word)
        0: begin rd[5:4] = arbmode; wr_ctrl = wr; end
        1: rd[NCH-1:0] = linkactive;
        2: begin rd = evt; wr_evt = wr; end
        default: begin rd = eventen; wr_even = wr; end
      endcase
    end else if (word >= 16 && ((word - 16) >> 3) < NCH && ((word - 16) & 7) <= 4) begin
      chn = (word - 16) >> 3;
      off = (word - 16) & 7;
      for (int c = 0; c < NCH; c++) begin
        if (c == chn) begin
          case (off)
            0: begin rd = txmode[c]; wr_tx[c] = wr; end
            1: begin rd = rxmode[c]; wr_rx[c] = wr; end
            2: begin rd = crdtinit[c]; wr_ci[c] = wr; end
            3: begin rd[15:0] = intrvl[c]; wr_iv[c] = wr; end
            default: rd = csr_txcrdt_status[c*32 +: 32];
          endcase
        end
      end
    end else begin
      err = 1'b1;
    end
  end

  always_comb begin
    set_ev = '0;
    for (int c = 0; c < NCH; c++) begin
      qual[c]       = phy_linkactive[c] & (deviceready | ~devicemode);
      load[c]       = (state[c] == SETTLE) && qual[c] && (cnt[c] == 16'(LINKDLY - 1));
      down_ev[c]    = (state[c] == UP) && !qual[c];
      set_ev[c]     = load[c];
      set_ev[8 + c] = down_ev[c];
    end
  end

  // Response channel: one outstanding request, response held until accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_resp_valid  <= 1'b0;
      reg_resp_rddata <= '0;
      reg_resp_error  <= 1'b0;
    end else if (acc) begin
      reg_resp_valid  <= 1'b1;
      reg_resp_rddata <= reg_req_write ? '0 : rd;
      reg_resp_error  <= err;
    end else if (reg_resp_ready) begin
      reg_resp_valid  <= 1'b0;
    end
  end

  // Per-channel link qualification FSMs
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (reset) begin
        state[c]      <= DOWN;
        cnt[c]        <= '0;
        linkactive[c] <= 1'b0;
      end else begin
        case (state[c])
          DOWN: if (qual[c]) begin
            cnt[c]   <= '0;
            state[c] <= SETTLE;
          end
          SETTLE: if (!qual[c]) begin
            state[c] <= DOWN;
          end else if (load[c]) begin
            state[c]      <= UP;
            linkactive[c] <= 1'b1;
          end else begin
            cnt[c] <= cnt[c] + 16'd1;
          end
          UP: if (!qual[c]) begin
            state[c]      <= DOWN;
            linkactive[c] <= 1'b0;
          end
          default: state[c] <= DOWN;
        endcase
      end
    end
  end

  // Channel config registers; the link-up load overrides a same-cycle software write
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (reset) begin
        txmode[c]   <= '0;
        rxmode[c]   <= '0;
        crdtinit[c] <= '0;
        intrvl[c]   <= INTRVLRST;
      end else begin
        if (load[c]) begin
          txmode[c]   <= {8'h00, phy_iow[c*8 +: 8], 8'h00, 8'h11};
          rxmode[c]   <= {8'h00, phy_iow[c*8 +: 8], 16'h0001};
          crdtinit[c] <= {2{crdt_sat(phy_iow[c*8 +: 8])}};
        end else begin
          if (wr_tx[c]) txmode[c]   <= reg_req_wrdata & 32'h00FF_0011;
          if (wr_rx[c]) rxmode[c]   <= reg_req_wrdata & 32'h00FF_0001;
          if (wr_ci[c]) crdtinit[c] <= reg_req_wrdata;
        end
        if (wr_iv[c]) intrvl[c] <= reg_req_wrdata[15:0];
      end
    end
  end

  // Global registers; a hardware event set beats a same-cycle W1C clear
  always_ff @(posedge clk) begin
    if (reset) begin
      arbmode <= '0;
      evt     <= '0;
      eventen <= '0;
      irq     <= 1'b0;
    end else begin
      if (wr_ctrl) arbmode <= reg_req_wrdata[5:4];
      if (wr_even) eventen <= reg_req_wrdata;
      evt <= (evt & ~(wr_evt ? reg_req_wrdata : '0)) | set_ev;
      irq <= |(evt & eventen);
    end
  end

  assign csr_arbmode = arbmode;

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign csr_txen[g]                   = linkactive[g] & txmode[g][0];
    assign csr_rxen[g]                   = linkactive[g] & rxmode[g][0];
    assign csr_txcrdt_en[g]              = txmode[g][4];
    assign csr_txiowidth[g*8 +: 8]       = txmode[g][23:16];
    assign csr_rxiowidth[g*8 +: 8]       = rxmode[g][23:16];
    assign csr_txcrdt_intrvl[g*16 +: 16] = intrvl[g];
    assign csr_rxcrdt_req_init[g*16 +: 16]  = crdtinit[g][15:0];
    assign csr_rxcrdt_resp_init[g*16 +: 16] = crdtinit[g][31:16];
  end

endmodule
